// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared constants and payload types for the FP ALU scheduler.
//   OP_ADD / OP_MUL    op-select encodings driven on alu_op
//   cmd_t / res_t      default-width command and result payloads
//   ptr_w()            queue pointer width (one wrap bit above the address)
// Optional feature macro used by the top: ALU_SCHED_STICKY_OVF_EN.
package alu_sched_pkg;

    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned TAG_W_DEF       = 4;
    localparam int unsigned DEPTH_DEF       = 4;
    localparam int unsigned ALU_LATENCY_DEF = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] x;
        logic [DATA_W_DEF-1:0] y;
        logic                  op;
        logic [TAG_W_DEF-1:0]  tag;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] result;
        logic                  overflow;
        logic [TAG_W_DEF-1:0]  tag;
    } res_t;

    // Pointer width: address bits plus one wrap bit to tell full from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// sched_fifo: synchronous FIFO with wrap-bit pointers and occupancy count.
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request (ignored when full, no pass-through)
//   pop               read request (ignored when empty)
//   head_c            combinational view of the oldest entry
//   full_c, empty_c   occupancy flags decoded from the pointers
//   count_c           number of stored entries (0..DEPTH)
module sched_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] count_c
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;

    // Pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset; reads are qualified by empty_c.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

    assign head_c  = mem[rd_ptr[ADDR_W-1:0]];
    assign count_c = wr_ptr - rd_ptr;
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: command/result wrapper around a fixed-latency FP add/mul ALU.
//   clk, rst                      clock, synchronous active-high reset (shared with ALU)
//   in_valid/in_ready             command handshake; in_x, in_y, in_op, in_tag payload
//   alu_x, alu_y, alu_op          operands for the ALU, zero when nothing issues
//   alu_result, alu_overflow      ALU outputs, valid ALU_LATENCY cycles after issue
//   out_valid/out_ready           result handshake; out_result, out_overflow, out_tag payload
//   busy                          anything queued, in flight or buffered
//   ovf_sticky, ovf_clear         only with ALU_SCHED_STICKY_OVF_EN: latched overflow seen on a pop
// Issue is credit-limited so every in-flight op has a guaranteed result-queue slot.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TAG_W       = TAG_W_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned ALU_LATENCY = ALU_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_overflow,
    output logic [TAG_W-1:0]  out_tag,
`ifdef ALU_SCHED_STICKY_OVF_EN
    output logic              ovf_sticky,
    input  logic              ovf_clear,
`endif
    output logic              busy
);

    localparam int unsigned CNT_W = ptr_w(DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic              op;
        logic [TAG_W-1:0]  tag;
    } cmd_q_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              overflow;
        logic [TAG_W-1:0]  tag;
    } res_q_t;

    cmd_q_t           cmd_in;
    cmd_q_t           cmd_head;
    res_q_t           res_in;
    res_q_t           res_head;
    logic             cmd_full;
    logic             cmd_empty;
    logic [CNT_W-1:0] cmd_cnt;
    logic             res_full;
    logic             res_empty;
    logic [CNT_W-1:0] res_cnt;
    logic             cmd_push;
    logic             res_pop;
    logic             issue;
    logic             cap;
    logic             credit_ok;

    logic [ALU_LATENCY-1:0] pipe_valid;
    logic [TAG_W-1:0]       pipe_tag [ALU_LATENCY];
    logic [CNT_W-1:0]       inflight_cnt;

    // Command queue.
    assign cmd_in   = '{x: in_x, y: in_y, op: in_op, tag: in_tag};
    assign in_ready = !rst && !cmd_full;
    assign cmd_push = in_valid && in_ready;

    sched_fifo #(.WIDTH($bits(cmd_q_t)), .DEPTH(DEPTH)) u_cmd_q (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_push),
        .push_data (cmd_in),
        .pop       (issue),
        .head_c    (cmd_head),
        .full_c    (cmd_full),
        .empty_c   (cmd_empty),
        .count_c   (cmd_cnt)
    );

    // Credit: registered occupancy only, a same-cycle result pop is not credited.
    assign credit_ok = (SUM_W'(inflight_cnt) + SUM_W'(res_cnt)) < SUM_W'(DEPTH);
    assign issue     = !rst && !cmd_empty && credit_ok;
    assign cap       = pipe_valid[ALU_LATENCY-1];

    // Operand drive toward the ALU.
    always_comb begin
        alu_x  = '0;
        alu_y  = '0;
        alu_op = OP_ADD;
        if (issue) begin
            alu_x  = cmd_head.x;
            alu_y  = cmd_head.y;
            alu_op = cmd_head.op;
        end
    end

    // In-flight valid pipe and its population count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid   <= '0;
            inflight_cnt <= '0;
        end else begin
            pipe_valid[0] <= issue;
            for (int i = 1; i < int'(ALU_LATENCY); i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
            inflight_cnt <= inflight_cnt + CNT_W'(issue) - CNT_W'(cap);
        end
    end

    // Tags ride alongside the valid bits; qualified by pipe_valid so no reset.
    always_ff @(posedge clk) begin
        pipe_tag[0] <= cmd_head.tag;
        for (int i = 1; i < int'(ALU_LATENCY); i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    // Result queue.
    assign res_in  = '{result: alu_result, overflow: alu_overflow, tag: pipe_tag[ALU_LATENCY-1]};
    assign res_pop = out_valid && out_ready;

    sched_fifo #(.WIDTH($bits(res_q_t)), .DEPTH(DEPTH)) u_res_q (
        .clk       (clk),
        .rst       (rst),
        .push      (cap),
        .push_data (res_in),
        .pop       (res_pop),
        .head_c    (res_head),
        .full_c    (res_full),
        .empty_c   (res_empty),
        .count_c   (res_cnt)
    );

    // Head payload is forced to zero whenever the queue is empty.
    assign out_valid    = !res_empty;
    assign out_result   = out_valid ? res_head.result : '0;
    assign out_overflow = out_valid && res_head.overflow;
    assign out_tag      = out_valid ? res_head.tag : '0;

    assign busy = (cmd_cnt != '0) || (inflight_cnt != '0) || !res_empty;

`ifdef ALU_SCHED_STICKY_OVF_EN
    // Sticky overflow; clear has priority over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst || ovf_clear) begin
            ovf_sticky <= 1'b0;
        end else if (res_pop && out_overflow) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    // The credit limit must keep a slot free for every captured result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(cap && res_full));
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Testbench for alu_op_scheduler: behavioural FP ALU, queue-based scoreboard,
// directed cases and randomized streams.
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned LAT    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_x;
    logic [DATA_W-1:0] in_y;
    logic              in_op;
    logic [TAG_W-1:0]  in_tag;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic              alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_overflow;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_overflow;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;
`ifdef ALU_SCHED_STICKY_OVF_EN
    logic              ovf_sticky;
    logic              ovf_clear;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pop    = 0;
    int   cyc      = 0;
    bit   rand_rdy = 1'b0;
    res_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_op_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_op        (in_op),
        .in_tag       (in_tag),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_tag      (out_tag),
`ifdef ALU_SCHED_STICKY_OVF_EN
        .ovf_sticky   (ovf_sticky),
        .ovf_clear    (ovf_clear),
`endif
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Single-precision helpers (denormals flushed, overflow to infinity).
    function automatic real sp_to_real(input logic [31:0] b);
        real m;
        real s;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        s = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) s = s * 2.0;
        else        for (int i = 0; i < -e; i++) s = s / 2.0;
        return b[31] ? -(m * s) : (m * s);
    endfunction

    function automatic logic [32:0] real_to_sp(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 33'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {1'b0, d[63], 31'd0};
        return {1'b0, d[63], e[7:0], d[51:29]};
    endfunction

    // {overflow, result} the ALU produces for one operation.
    function automatic logic [32:0] alu_fn(input logic [31:0] x, input logic [31:0] y, input logic op);
        if (op == OP_MUL) return real_to_sp(sp_to_real(x) * sp_to_real(y));
        return real_to_sp(sp_to_real(x) + sp_to_real(y));
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(60, 200));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    // Fixed-latency ALU model sharing the scheduler reset.
    logic [DATA_W-1:0] a_res [LAT];
    logic              a_ovf [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LAT); i++) begin
                a_res[i] <= '0;
                a_ovf[i] <= 1'b0;
            end
        end else begin
            {a_ovf[0], a_res[0]} <= alu_fn(alu_x, alu_y, alu_op);
            for (int i = 1; i < int'(LAT); i++) begin
                a_res[i] <= a_res[i-1];
                a_ovf[i] <= a_ovf[i-1];
            end
        end
    end
    assign alu_result   = a_res[LAT-1];
    assign alu_overflow = a_ovf[LAT-1];

    // Scoreboard: everything accepted and not yet delivered, in order.
    always @(negedge clk) begin : mon
        res_t        e;
        logic [32:0] r;
        if (rst) begin
            exp_q.delete();
        end else begin
            check("busy", 64'(busy), 64'(exp_q.size() != 0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(out_tag), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(out_result), 64'(e.result));
                    check("overflow", 64'(out_overflow), 64'(e.overflow));
                    check("tag", 64'(out_tag), 64'(e.tag));
                    n_pop++;
                end
            end
            if (in_valid && in_ready) begin
                r = alu_fn(in_x, in_y, in_op);
                exp_q.push_back('{result: r[31:0], overflow: r[32], tag: in_tag});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic op, input logic [3:0] tag);
        bit hs = 1'b0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_op = op;
        in_tag = tag;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clk);
            hs = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!hs) check("send_timeout", 64'(hs), 64'd1);
    endtask

    task automatic wait_out(output int t);
        bit seen = 1'b0;
        t = -1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        if (!seen) check("out_timeout", 64'(seen), 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
            step();
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic directed(input logic [31:0] x, input logic [31:0] y, input logic op,
                            input logic [3:0] tag, input logic [31:0] exp_res, input logic exp_ovf);
        int t0;
        int t1;
        t0 = cyc;
        send(x, y, op, tag);
        wait_out(t1);
        check("dir_latency", 64'(t1 - t0), 64'd5);
        check("dir_result", 64'(out_result), 64'(exp_res));
        check("dir_overflow", 64'(out_overflow), 64'(exp_ovf));
        check("dir_tag", 64'(out_tag), 64'(tag));
        step();
    endtask

    initial begin
        int k;
        int p0;
        int seen;
        rst = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        in_op = 1'b0;
        in_tag = '0;
        out_ready = 1'b0;
`ifdef ALU_SCHED_STICKY_OVF_EN
        ovf_clear = 1'b0;
`endif
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_ovf", 64'(out_overflow), 64'd0);
        check("rst_alu_xy", 64'({alu_x, alu_y}), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
`ifdef ALU_SCHED_STICKY_OVF_EN
        check("rst_sticky", 64'(ovf_sticky), 64'd0);
`endif
        step();
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        step();

        // Directed add, mul and overflowing mul.
        out_ready = 1'b1;
        directed(32'h3F80_0000, 32'h4000_0000, OP_ADD, 4'd1, 32'h4040_0000, 1'b0);
        directed(32'h4000_0000, 32'h4040_0000, OP_MUL, 4'd2, 32'h40C0_0000, 1'b0);
        directed(32'h7F00_0000, 32'h7F00_0000, OP_MUL, 4'd3, 32'h7F80_0000, 1'b1);
`ifdef ALU_SCHED_STICKY_OVF_EN
        @(negedge clk);
        check("sticky_set", 64'(ovf_sticky), 64'd1);
        step();
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        @(negedge clk);
        check("sticky_clear", 64'(ovf_sticky), 64'd0);
        step();
`endif

        // Back-pressure: 4 in flight/buffered plus 4 queued, ninth refused.
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = 1'b1;
            in_tag = 4'(k);
            in_x = rand_fp();
            in_y = rand_fp();
            in_op = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) k++;
            step();
        end
        @(negedge clk);
        check("bp_accepted", 64'(k), 64'd8);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        p0 = n_pop;
        wait_drain(100);
        check("bp_drained", 64'(n_pop - p0), 64'd8);

        // Streaming with a ready consumer.
        p0 = n_pop;
        for (int i = 0; i < 16; i++) send(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 4'(i));
        wait_drain(100);
        check("stream_count", 64'(n_pop - p0), 64'd16);

        // Random gaps and random consumer back-pressure.
        rand_rdy = 1'b1;
        p0 = n_pop;
        for (int i = 0; i < 40; i++) begin
            send(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 4'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end
        wait_drain(400);
        check("random_count", 64'(n_pop - p0), 64'd40);
        rand_rdy = 1'b0;
        out_ready = 1'b0;

        // Reset with three ops in flight; nothing may surface afterwards.
        for (int i = 0; i < 3; i++) send(rand_fp(), rand_fp(), OP_ADD, 4'(i + 10));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_stale", 64'(seen), 64'd0);
        step();
        p0 = n_pop;
        send(32'h3F80_0000, 32'h3F80_0000, OP_ADD, 4'd5);
        send(32'h4000_0000, 32'h4000_0000, OP_MUL, 4'd6);
        wait_drain(50);
        check("post_flush_count", 64'(n_pop - p0), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
